// File: rtl/gyro_serial_pkg.sv
// Shared constants and enumerations for the gyro serial responder.
package gyro_serial_pkg;

  localparam int unsigned FRAME_BITS = 48;
  localparam int unsigned RESP_BITS  = 16;

  localparam logic [15:0] RESP_NOP     = 16'h0000;
  localparam logic [15:0] RESP_ILLEGAL = 16'hDEAD;
  localparam logic [15:0] RESP_SHORT   = 16'hBAD0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_EXEC,
    S_WAIT_LOW
  } state_e;

endpackage

// File: rtl/gyro_sig_sync.sv
// 2-FF synchronizer with registered rise/fall pulses for an asynchronous level.
module gyro_sig_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic       meta_q, sync_q, prev_q;
  logic       rise_q, fall_q;
  logic [2:0] vld_q;

  // Edges are suppressed until prev_q holds a real sample, so a level that is
  // already high when reset releases never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      vld_q  <= {vld_q[1:0], 1'b1};
      rise_q <= vld_q[2] & sync_q & ~prev_q;
      fall_q <= vld_q[2] & ~sync_q & prev_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gyro_serial_responder.sv
// Device-side gyro serial link: receives 48-bit commands, executes them against
// a small register file and shifts the 16-bit response out during the next frame.
module gyro_serial_responder
  import gyro_serial_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter logic [15:0] ID_VALUE = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        txclk,
  input  logic        DTX,
  input  logic        DSYNC,
  output logic        DRX,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] error_count,
  output logic [47:0] last_cmd
);

  localparam int unsigned RXC_W = $clog2(FRAME_BITS + 1);
  localparam int unsigned TXC_W = $clog2(RESP_BITS + 1);
  localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(FRAME_BITS - 1);
  localparam logic [TXC_W-1:0] TX_END  = TXC_W'(RESP_BITS);

  logic tx_rise, tx_fall, txclk_lvl_unused;
  logic ds_rise, ds_fall, dsync_s;
  logic dtx_meta_q, dtx_s;

  gyro_sig_sync u_txclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (txclk),
    .sync_o (txclk_lvl_unused),
    .rise_o (tx_rise),
    .fall_o (tx_fall)
  );

  gyro_sig_sync u_dsync_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (DSYNC),
    .sync_o (dsync_s),
    .rise_o (ds_rise),
    .fall_o (ds_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dtx_meta_q <= 1'b0;
      dtx_s      <= 1'b0;
    end else begin
      dtx_meta_q <= DTX;
      dtx_s      <= dtx_meta_q;
    end
  end

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  rx_sr_q, rx_sr_d;
  logic [RXC_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [TXC_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic [15:0]            resp_q, resp_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [15:0]            err_cnt_q, err_cnt_d;
  logic [FRAME_BITS-1:0]  last_cmd_q, last_cmd_d;
  logic [15:0]            regs_q [2**ADDR_W];

  logic                   frame_start;
  logic [3:0]             cmd_op;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [15:0]            cmd_data;
  logic [15:0]            exec_resp;
  logic                   exec_wr;
  logic                   wr_en;

  assign frame_start = enable & ds_rise;
  assign cmd_op      = rx_sr_q[FRAME_BITS-1 -: 4];
  assign cmd_addr    = rx_sr_q[32 +: ADDR_W];
  assign cmd_data    = rx_sr_q[15:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (frame_start) state_d = S_RECV;
      S_RECV: begin
        if (!enable || ds_fall)                  state_d = S_IDLE;
        else if (tx_rise && rx_cnt_q == RX_LAST) state_d = S_EXEC;
      end
      S_EXEC:     state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!enable || !dsync_s) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    DRX  = enable & resp_q[15];
  end

  // Register 0 is never written; reads of it return the ID constant.
  always_comb begin
    exec_resp = RESP_NOP;
    exec_wr   = 1'b0;
    case (cmd_op)
      OP_WRITE: begin
        if (cmd_addr == '0) begin
          exec_resp = ID_VALUE;
        end else begin
          exec_resp = cmd_data;
          exec_wr   = 1'b1;
        end
      end
      OP_READ:  exec_resp = (cmd_addr == '0) ? ID_VALUE : regs_q[cmd_addr];
      OP_NOP:   exec_resp = RESP_NOP;
      default:  exec_resp = RESP_ILLEGAL;
    endcase
  end

  always_comb begin
    rx_sr_d     = rx_sr_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    resp_d      = resp_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    last_cmd_d  = last_cmd_q;
    wr_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          rx_cnt_d = '0;
          tx_cnt_d = '0;
          // A txclk rise coincident with the frame start is the first bit.
          if (tx_rise) begin
            rx_sr_d  = {rx_sr_q[FRAME_BITS-2:0], dtx_s};
            rx_cnt_d = RXC_W'(1);
          end
        end
      end
      S_RECV: begin
        if (!enable) begin
          resp_d = '0;
        end else if (ds_fall) begin
          resp_d = RESP_SHORT;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else begin
          if (tx_rise) begin
            rx_sr_d  = {rx_sr_q[FRAME_BITS-2:0], dtx_s};
            rx_cnt_d = rx_cnt_q + RXC_W'(1);
          end
          if (tx_fall && tx_cnt_q < TX_END) begin
            resp_d   = {resp_q[14:0], 1'b0};
            tx_cnt_d = tx_cnt_q + TXC_W'(1);
          end
        end
      end
      S_EXEC: begin
        resp_d      = exec_resp;
        last_cmd_d  = rx_sr_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
        wr_en       = exec_wr;
      end
      S_WAIT_LOW: if (!enable) resp_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr_q     <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      resp_q      <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      last_cmd_q  <= '0;
    end else begin
      rx_sr_q     <= rx_sr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      resp_q      <= resp_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        regs_q <= '{default: '0};
    else if (wr_en) regs_q[cmd_addr] <= cmd_data;
  end

  assign frame_count = frame_cnt_q;
  assign error_count = err_cnt_q;
  assign last_cmd    = last_cmd_q;

endmodule

// File: tb/tb_gyro_serial_responder.sv
// Directed bench for gyro_serial_responder: drives tester-side frames and checks responses.
module tb_gyro_serial_responder;

  localparam int HALF = 8;

  logic        clk;
  logic        rst, enable, txclk, DTX, DSYNC;
  logic        DRX, busy;
  logic [15:0] frame_count, error_count;
  logic [47:0] last_cmd;

  int vectors;
  int miscompares;

  gyro_serial_responder #(.ADDR_W(4), .ID_VALUE(16'hA55A)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .txclk       (txclk),
    .DTX         (DTX),
    .DSYNC       (DSYNC),
    .DRX         (DRX),
    .busy        (busy),
    .frame_count (frame_count),
    .error_count (error_count),
    .last_cmd    (last_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] mk_cmd(input logic [3:0] op, input logic [7:0] addr,
                                         input logic [15:0] data);
    return {op, 4'h0, addr, 16'h0000, data};
  endfunction

  // Sends nbits MSB-first from vec; samples DRX just before each txclk rise.
  task automatic send_frame(input logic [63:0] vec, input int nbits, input bit hold,
                            output logic [15:0] resp, output bit tail_bad);
    resp     = '0;
    tail_bad = 1'b0;
    @(negedge clk);
    DSYNC = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      DTX = vec[nbits-1-i];
      repeat (HALF) @(negedge clk);
      if (i < 16) resp[15-i] = DRX;
      else if (DRX !== 1'b0) tail_bad = 1'b1;
      txclk = 1'b1;
      repeat (HALF) @(negedge clk);
      txclk = 1'b0;
    end
    if (!hold) begin
      repeat (HALF) @(negedge clk);
      DSYNC = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; txclk = 1'b0; DTX = 1'b0; DSYNC = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (DRX !== 1'b0) begin miscompares++; $display("FAIL reset_drx: got %b expected 0", DRX); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (frame_count !== 16'h0) begin miscompares++; $display("FAIL reset_fc: got %h expected 0000", frame_count); end
    vectors++; if (error_count !== 16'h0) begin miscompares++; $display("FAIL reset_ec: got %h expected 0000", error_count); end
    vectors++; if (last_cmd !== 48'h0) begin miscompares++; $display("FAIL reset_last_cmd: got %h expected 0", last_cmd); end
  endtask

  task automatic test_read_id();
    logic [15:0] r; bit t; logic [47:0] c;
    c = mk_cmd(4'h2, 8'h00, 16'h0000);
    send_frame({16'h0, c}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL read_id_first_resp: got %h expected 0000", r); end
    vectors++; if (frame_count !== 16'd1) begin miscompares++; $display("FAIL read_id_fc: got %0d expected 1", frame_count); end
    vectors++; if (last_cmd !== c) begin miscompares++; $display("FAIL read_id_last_cmd: got %h expected %h", last_cmd, c); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_id_busy: got %b expected 0", busy); end
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'hA55A) begin miscompares++; $display("FAIL read_id_resp: got %h expected a55a", r); end
    vectors++; if (t !== 1'b0) begin miscompares++; $display("FAIL read_id_tail: got %b expected 0", t); end
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL read_id_fc2: got %0d expected 2", frame_count); end
  endtask

  task automatic test_write_read();
    logic [15:0] r; bit t;
    send_frame({16'h0, mk_cmd(4'h1, 8'h03, 16'h1234)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL wr_prev_resp: got %h expected 0000", r); end
    send_frame({16'h0, mk_cmd(4'h2, 8'h03, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h1234) begin miscompares++; $display("FAIL wr_write_resp: got %h expected 1234", r); end
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h1234) begin miscompares++; $display("FAIL wr_read_resp: got %h expected 1234", r); end
    vectors++; if (frame_count !== 16'd5) begin miscompares++; $display("FAIL wr_fc: got %0d expected 5", frame_count); end
  endtask

  task automatic test_short_frame();
    logic [15:0] r; bit t;
    send_frame({16'h0, mk_cmd(4'h1, 8'h07, 16'hFFFF)}, 20, 1'b0, r, t);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL short_prev_resp: got %h expected 0000", r); end
    vectors++; if (error_count !== 16'd1) begin miscompares++; $display("FAIL short_ec: got %0d expected 1", error_count); end
    vectors++; if (frame_count !== 16'd5) begin miscompares++; $display("FAIL short_fc: got %0d expected 5", frame_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL short_busy: got %b expected 0", busy); end
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'hBAD0) begin miscompares++; $display("FAIL short_resp: got %h expected bad0", r); end
    vectors++; if (t !== 1'b0) begin miscompares++; $display("FAIL short_tail: got %b expected 0", t); end
    vectors++; if (frame_count !== 16'd6) begin miscompares++; $display("FAIL short_fc2: got %0d expected 6", frame_count); end
  endtask

  task automatic test_illegal_and_long();
    logic [15:0] r; bit t; logic [47:0] c;
    send_frame({16'h0, mk_cmd(4'h7, 8'h02, 16'h1111)}, 48, 1'b0, r, t);
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'hDEAD) begin miscompares++; $display("FAIL illegal_resp: got %h expected dead", r); end
    c = mk_cmd(4'h1, 8'h05, 16'h5A5A);
    send_frame({12'h0, c, 4'hF}, 52, 1'b0, r, t);
    vectors++; if (last_cmd !== c) begin miscompares++; $display("FAIL long_last_cmd: got %h expected %h", last_cmd, c); end
    vectors++; if (frame_count !== 16'd9) begin miscompares++; $display("FAIL long_fc: got %0d expected 9", frame_count); end
    send_frame({16'h0, mk_cmd(4'h2, 8'h05, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h5A5A) begin miscompares++; $display("FAIL long_write_resp: got %h expected 5a5a", r); end
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h5A5A) begin miscompares++; $display("FAIL long_read_resp: got %h expected 5a5a", r); end
  endtask

  task automatic test_write_id();
    logic [15:0] r; bit t;
    send_frame({16'h0, mk_cmd(4'h1, 8'h00, 16'hFFFF)}, 48, 1'b0, r, t);
    send_frame({16'h0, mk_cmd(4'h2, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'hA55A) begin miscompares++; $display("FAIL wid_write_resp: got %h expected a55a", r); end
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'hA55A) begin miscompares++; $display("FAIL wid_read_resp: got %h expected a55a", r); end
    vectors++; if (frame_count !== 16'd14) begin miscompares++; $display("FAIL wid_fc: got %0d expected 14", frame_count); end
  endtask

  task automatic test_enable();
    logic [15:0] r; bit t;
    send_frame({16'h0, mk_cmd(4'h2, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    enable = 1'b0;
    send_frame({16'h0, mk_cmd(4'h1, 8'h06, 16'h4321)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL dis_drx: got %h expected 0000", r); end
    vectors++; if (frame_count !== 16'd15) begin miscompares++; $display("FAIL dis_fc: got %0d expected 15", frame_count); end
    enable = 1'b1;
    repeat (4) @(negedge clk);
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 10, 1'b1, r, t);
    vectors++; if (r !== 16'hA540) begin miscompares++; $display("FAIL abort_partial_resp: got %h expected a540", r); end
    enable = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    DSYNC = 1'b0;
    repeat (HALF) @(negedge clk);
    enable = 1'b1;
    repeat (HALF) @(negedge clk);
    vectors++; if (frame_count !== 16'd15) begin miscompares++; $display("FAIL abort_fc: got %0d expected 15", frame_count); end
    vectors++; if (error_count !== 16'd1) begin miscompares++; $display("FAIL abort_ec: got %0d expected 1", error_count); end
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL abort_resp_cleared: got %h expected 0000", r); end
    vectors++; if (frame_count !== 16'd16) begin miscompares++; $display("FAIL abort_fc2: got %0d expected 16", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] r; bit t;
    send_frame({16'h0, mk_cmd(4'h2, 8'h03, 16'h0000)}, 30, 1'b1, r, t);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (DRX !== 1'b0) begin miscompares++; $display("FAIL mid_rst_drx: got %b expected 0", DRX); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL mid_rst_fc: got %0d expected 0", frame_count); end
    // DSYNC is still high here; the bench must see no spurious frame start.
    repeat (2 * HALF) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_no_start: got %b expected 0", busy); end
    DSYNC = 1'b0;
    repeat (HALF) @(negedge clk);
    send_frame({16'h0, mk_cmd(4'h2, 8'h03, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (frame_count !== 16'd1) begin miscompares++; $display("FAIL mid_fc: got %0d expected 1", frame_count); end
    send_frame({16'h0, mk_cmd(4'h0, 8'h00, 16'h0000)}, 48, 1'b0, r, t);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL mid_reg_cleared: got %h expected 0000", r); end
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL mid_fc2: got %0d expected 2", frame_count); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_read_id();
    test_write_read();
    test_short_frame();
    test_illegal_and_long();
    test_write_id();
    test_enable();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
